// File: rtl/idex_stage_pkg.sv
// Shared pipeline definitions: default widths, control-bundle layout and the
// flag-clear helper used by every pipeline register.
package idex_stage_pkg;

    localparam int DATA_W_DEF = 16;
    localparam int REG_AW_DEF = 3;
    localparam int CTRL_W_DEF = 8;

    // Field offsets inside the opaque EX/MEM/WB control bundle
    localparam int CTRL_ALUOP_LSB    = 0;
    localparam int CTRL_ALUOP_W      = 4;
    localparam int CTRL_MEMWRITE_BIT = 4;
    localparam int CTRL_MEMTOREG_BIT = 5;
    localparam int CTRL_BRTYPE_LSB   = 6;
    localparam int CTRL_BRTYPE_W     = 2;

    // Per-instruction flag vector carried by pipeline registers
    localparam int FLAG_W        = 4;
    localparam int FLAG_REGWRITE = 3;
    localparam int FLAG_LOAD     = 2;
    localparam int FLAG_STORE    = 1;
    localparam int FLAG_HALT     = 0;

    typedef logic [FLAG_W-1:0] flags_t;

    // All-ones when the slot keeps its flags, all-zeros when it becomes a bubble
    function automatic flags_t flag_mask(input logic keep);
        return keep ? '1 : '0;
    endfunction

endpackage

// File: rtl/idex_stage_hazard_detect.sv
// Load-use hazard detection and front-end hold request. Purely combinational,
// shared with the IF-stage PC-hold logic.
module idex_stage_hazard_detect
    import idex_stage_pkg::*;
#(
    parameter int REG_AW = REG_AW_DEF
) (
    input  logic              valid_idex_i,
    input  logic              load_idex_i,
    input  logic              regwrite_idex_i,
    input  logic [REG_AW-1:0] wrr_idex_i,
    input  logic              valid_ifid_i,
    input  logic              use_rs1_i,
    input  logic [REG_AW-1:0] rs1_i,
    input  logic              use_rs2_i,
    input  logic [REG_AW-1:0] rs2_i,
    input  logic              stall_ex_i,
    input  logic              halted_i,
    input  logic              flush_i,
    output logic              lu_haz_o,
    output logic              stall_ifid_o
);

    logic rs1_hit;
    logic rs2_hit;

    // Compare each consumed source against the load destination sitting in ID/EX
    always_comb begin
        rs1_hit      = use_rs1_i & (rs1_i == wrr_idex_i);
        rs2_hit      = use_rs2_i & (rs2_i == wrr_idex_i);
        lu_haz_o     = valid_idex_i & load_idex_i & regwrite_idex_i & valid_ifid_i
                     & (rs1_hit | rs2_hit);
        // A redirect discards the younger stages, so holding them would be pointless
        stall_ifid_o = (lu_haz_o | stall_ex_i | halted_i) & ~flush_i;
    end

endmodule

// File: rtl/idex_stage.sv
// ID/EX pipeline register with load-use bubble insertion, flush, sticky halt
// capture and saturating stall/bubble counters.
module idex_stage
    import idex_stage_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int REG_AW = REG_AW_DEF,
    parameter int CTRL_W = CTRL_W_DEF,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              valid_IFID,
    input  logic [REG_AW-1:0] Rd1Addr_IFID,
    input  logic [REG_AW-1:0] Rd2Addr_IFID,
    input  logic              useRs1_IFID,
    input  logic              useRs2_IFID,
    input  logic [DATA_W-1:0] Rd1_IFID,
    input  logic [DATA_W-1:0] Rd2_IFID,
    input  logic [DATA_W-1:0] Imm_IFID,
    input  logic [REG_AW-1:0] WrR_IFID,
    input  logic              RegWrite_IFID,
    input  logic              loadDetect_IFID,
    input  logic              storeDetect_IFID,
    input  logic              halt_IFID,
    input  logic [CTRL_W-1:0] ctrl_IFID,
    input  logic              takeBranch_EXMEM,
    input  logic              stall_EX,
    output logic              valid_IDEX,
    output logic [REG_AW-1:0] Rd1Addr_IDEX,
    output logic [REG_AW-1:0] Rd2Addr_IDEX,
    output logic [DATA_W-1:0] Rd1_IDEX,
    output logic [DATA_W-1:0] Rd2_IDEX,
    output logic [DATA_W-1:0] Imm_IDEX,
    output logic [REG_AW-1:0] WrR_IDEX,
    output logic              RegWrite_IDEX,
    output logic              loadDetect_IDEX,
    output logic              storeDetect_IDEX,
    output logic              halt_IDEX,
    output logic [CTRL_W-1:0] ctrl_IDEX,
    output logic              stall_IFID,
    output logic              halted,
    output logic [CNT_W-1:0]  stallCnt,
    output logic [CNT_W-1:0]  bubbleCnt
);

    logic              valid_q,      valid_d;
    logic [REG_AW-1:0] rs1a_q,       rs1a_d;
    logic [REG_AW-1:0] rs2a_q,       rs2a_d;
    logic [DATA_W-1:0] rd1_q,        rd1_d;
    logic [DATA_W-1:0] rd2_q,        rd2_d;
    logic [DATA_W-1:0] imm_q,        imm_d;
    logic [REG_AW-1:0] wrr_q,        wrr_d;
    flags_t            flags_q,      flags_d;
    logic [CTRL_W-1:0] ctrl_q,       ctrl_d;
    logic              halted_q,     halted_d;
    logic [CNT_W-1:0]  stall_cnt_q,  stall_cnt_d;
    logic [CNT_W-1:0]  bubble_cnt_q, bubble_cnt_d;

    flags_t flags_in;
    logic   lu_haz;

    // Counters stick at all-ones rather than wrapping
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    idex_stage_hazard_detect #(
        .REG_AW (REG_AW)
    ) u_hazard (
        .valid_idex_i    (valid_q),
        .load_idex_i     (flags_q[FLAG_LOAD]),
        .regwrite_idex_i (flags_q[FLAG_REGWRITE]),
        .wrr_idex_i      (wrr_q),
        .valid_ifid_i    (valid_IFID),
        .use_rs1_i       (useRs1_IFID),
        .rs1_i           (Rd1Addr_IFID),
        .use_rs2_i       (useRs2_IFID),
        .rs2_i           (Rd2Addr_IFID),
        .stall_ex_i      (stall_EX),
        .halted_i        (halted_q),
        .flush_i         (takeBranch_EXMEM),
        .lu_haz_o        (lu_haz),
        .stall_ifid_o    (stall_IFID)
    );

    // Next-state selection: flush, downstream hold, halt hold, bubble, capture
    always_comb begin
        flags_in     = {RegWrite_IFID, loadDetect_IFID, storeDetect_IFID, halt_IFID}
                     & flag_mask(valid_IFID);
        valid_d      = valid_q;
        rs1a_d       = rs1a_q;
        rs2a_d       = rs2a_q;
        rd1_d        = rd1_q;
        rd2_d        = rd2_q;
        imm_d        = imm_q;
        wrr_d        = wrr_q;
        flags_d      = flags_q;
        ctrl_d       = ctrl_q;
        halted_d     = halted_q;
        bubble_cnt_d = bubble_cnt_q;

        if (takeBranch_EXMEM) begin
            // A HALT on the wrong path must not freeze the pipeline
            valid_d  = 1'b0;
            flags_d  = flag_mask(1'b0);
            halted_d = 1'b0;
        end else if (stall_EX || halted_q) begin
            // Hold everything; a pending hazard is re-evaluated next cycle
        end else if (lu_haz) begin
            // Data fields keep stale contents; only valid and flags matter in a bubble
            valid_d      = 1'b0;
            flags_d      = flag_mask(1'b0);
            bubble_cnt_d = sat_inc(bubble_cnt_q);
        end else begin
            valid_d  = valid_IFID;
            rs1a_d   = Rd1Addr_IFID;
            rs2a_d   = Rd2Addr_IFID;
            rd1_d    = Rd1_IFID;
            rd2_d    = Rd2_IFID;
            imm_d    = Imm_IFID;
            wrr_d    = WrR_IFID;
            flags_d  = flags_in;
            ctrl_d   = ctrl_IFID;
            halted_d = flags_in[FLAG_HALT];
        end

        stall_cnt_d = stall_IFID ? sat_inc(stall_cnt_q) : stall_cnt_q;
    end

    // ID/EX register, halt flag and counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q      <= 1'b0;
            rs1a_q       <= '0;
            rs2a_q       <= '0;
            rd1_q        <= '0;
            rd2_q        <= '0;
            imm_q        <= '0;
            wrr_q        <= '0;
            flags_q      <= '0;
            ctrl_q       <= '0;
            halted_q     <= 1'b0;
            stall_cnt_q  <= '0;
            bubble_cnt_q <= '0;
        end else begin
            valid_q      <= valid_d;
            rs1a_q       <= rs1a_d;
            rs2a_q       <= rs2a_d;
            rd1_q        <= rd1_d;
            rd2_q        <= rd2_d;
            imm_q        <= imm_d;
            wrr_q        <= wrr_d;
            flags_q      <= flags_d;
            ctrl_q       <= ctrl_d;
            halted_q     <= halted_d;
            stall_cnt_q  <= stall_cnt_d;
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    assign valid_IDEX       = valid_q;
    assign Rd1Addr_IDEX     = rs1a_q;
    assign Rd2Addr_IDEX     = rs2a_q;
    assign Rd1_IDEX         = rd1_q;
    assign Rd2_IDEX         = rd2_q;
    assign Imm_IDEX         = imm_q;
    assign WrR_IDEX         = wrr_q;
    assign RegWrite_IDEX    = flags_q[FLAG_REGWRITE];
    assign loadDetect_IDEX  = flags_q[FLAG_LOAD];
    assign storeDetect_IDEX = flags_q[FLAG_STORE];
    assign halt_IDEX        = flags_q[FLAG_HALT];
    assign ctrl_IDEX        = ctrl_q;
    assign halted           = halted_q;
    assign stallCnt         = stall_cnt_q;
    assign bubbleCnt        = bubble_cnt_q;

endmodule

// File: tb/tb_idex_stage.sv
// Directed scoreboard bench for idex_stage: each cycle states its intended
// outcome (capture, hold, bubble, flush) and the expected register image is
// queued at drive time and compared after the clock edge.
module tb_idex_stage;

    typedef struct packed {
        logic        v;
        logic [2:0]  a1;
        logic        u1;
        logic [2:0]  a2;
        logic        u2;
        logic [15:0] d1;
        logic [15:0] d2;
        logic [15:0] imm;
        logic [2:0]  wr;
        logic        rw;
        logic        ld;
        logic        st;
        logic        ht;
        logic [7:0]  ctrl;
    } instr_t;

    typedef struct packed {
        logic        v;
        logic [2:0]  a1;
        logic [2:0]  a2;
        logic [15:0] d1;
        logic [15:0] d2;
        logic [15:0] imm;
        logic [2:0]  wr;
        logic        rw;
        logic        ld;
        logic        st;
        logic        ht;
        logic [7:0]  ctrl;
        logic        halted;
        logic [15:0] sc;
        logic [15:0] bc;
    } exp_t;

    localparam int CAP   = 0;
    localparam int HOLD  = 1;
    localparam int BUB   = 2;
    localparam int FLUSH = 3;

    logic        clk;
    logic        rst_n;
    logic        valid_IFID;
    logic [2:0]  Rd1Addr_IFID, Rd2Addr_IFID;
    logic        useRs1_IFID, useRs2_IFID;
    logic [15:0] Rd1_IFID, Rd2_IFID, Imm_IFID;
    logic [2:0]  WrR_IFID;
    logic        RegWrite_IFID, loadDetect_IFID, storeDetect_IFID, halt_IFID;
    logic [7:0]  ctrl_IFID;
    logic        takeBranch_EXMEM, stall_EX;
    logic        valid_IDEX;
    logic [2:0]  Rd1Addr_IDEX, Rd2Addr_IDEX;
    logic [15:0] Rd1_IDEX, Rd2_IDEX, Imm_IDEX;
    logic [2:0]  WrR_IDEX;
    logic        RegWrite_IDEX, loadDetect_IDEX, storeDetect_IDEX, halt_IDEX;
    logic [7:0]  ctrl_IDEX;
    logic        stall_IFID, halted;
    logic [15:0] stallCnt, bubbleCnt;

    int   n_vec = 0;
    int   n_err = 0;
    exp_t sb_q[$];
    exp_t cur;

    idex_stage dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .valid_IFID       (valid_IFID),
        .Rd1Addr_IFID     (Rd1Addr_IFID),
        .Rd2Addr_IFID     (Rd2Addr_IFID),
        .useRs1_IFID      (useRs1_IFID),
        .useRs2_IFID      (useRs2_IFID),
        .Rd1_IFID         (Rd1_IFID),
        .Rd2_IFID         (Rd2_IFID),
        .Imm_IFID         (Imm_IFID),
        .WrR_IFID         (WrR_IFID),
        .RegWrite_IFID    (RegWrite_IFID),
        .loadDetect_IFID  (loadDetect_IFID),
        .storeDetect_IFID (storeDetect_IFID),
        .halt_IFID        (halt_IFID),
        .ctrl_IFID        (ctrl_IFID),
        .takeBranch_EXMEM (takeBranch_EXMEM),
        .stall_EX         (stall_EX),
        .valid_IDEX       (valid_IDEX),
        .Rd1Addr_IDEX     (Rd1Addr_IDEX),
        .Rd2Addr_IDEX     (Rd2Addr_IDEX),
        .Rd1_IDEX         (Rd1_IDEX),
        .Rd2_IDEX         (Rd2_IDEX),
        .Imm_IDEX         (Imm_IDEX),
        .WrR_IDEX         (WrR_IDEX),
        .RegWrite_IDEX    (RegWrite_IDEX),
        .loadDetect_IDEX  (loadDetect_IDEX),
        .storeDetect_IDEX (storeDetect_IDEX),
        .halt_IDEX        (halt_IDEX),
        .ctrl_IDEX        (ctrl_IDEX),
        .stall_IFID       (stall_IFID),
        .halted           (halted),
        .stallCnt         (stallCnt),
        .bubbleCnt        (bubbleCnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic cmp_outs(input exp_t e);
        chk("valid_IDEX",       64'(valid_IDEX),       64'(e.v));
        chk("Rd1Addr_IDEX",     64'(Rd1Addr_IDEX),     64'(e.a1));
        chk("Rd2Addr_IDEX",     64'(Rd2Addr_IDEX),     64'(e.a2));
        chk("Rd1_IDEX",         64'(Rd1_IDEX),         64'(e.d1));
        chk("Rd2_IDEX",         64'(Rd2_IDEX),         64'(e.d2));
        chk("Imm_IDEX",         64'(Imm_IDEX),         64'(e.imm));
        chk("WrR_IDEX",         64'(WrR_IDEX),         64'(e.wr));
        chk("RegWrite_IDEX",    64'(RegWrite_IDEX),    64'(e.rw));
        chk("loadDetect_IDEX",  64'(loadDetect_IDEX),  64'(e.ld));
        chk("storeDetect_IDEX", 64'(storeDetect_IDEX), 64'(e.st));
        chk("halt_IDEX",        64'(halt_IDEX),        64'(e.ht));
        chk("ctrl_IDEX",        64'(ctrl_IDEX),        64'(e.ctrl));
        chk("halted",           64'(halted),           64'(e.halted));
        chk("stallCnt",         64'(stallCnt),         64'(e.sc));
        chk("bubbleCnt",        64'(bubbleCnt),        64'(e.bc));
    endtask

    function automatic instr_t mk(input logic v, input logic [2:0] a1, input logic u1,
                                  input logic [2:0] a2, input logic u2, input logic [2:0] wr,
                                  input logic rw, input logic ld, input logic st, input logic ht);
        instr_t i;
        i.v    = v;   i.a1 = a1; i.u1 = u1; i.a2 = a2; i.u2 = u2;
        i.wr   = wr;  i.rw = rw; i.ld = ld; i.st = st; i.ht = ht;
        i.d1   = 16'($urandom);
        i.d2   = 16'($urandom);
        i.imm  = 16'($urandom);
        i.ctrl = 8'($urandom);
        return i;
    endfunction

    function automatic instr_t rnd_instr();
        instr_t i;
        i = instr_t'({$urandom, $urandom, $urandom});
        i.v = 1'b1;
        return i;
    endfunction

    task automatic apply(input instr_t i);
        valid_IFID       = i.v;
        Rd1Addr_IFID     = i.a1;
        useRs1_IFID      = i.u1;
        Rd2Addr_IFID     = i.a2;
        useRs2_IFID      = i.u2;
        Rd1_IFID         = i.d1;
        Rd2_IFID         = i.d2;
        Imm_IFID         = i.imm;
        WrR_IFID         = i.wr;
        RegWrite_IFID    = i.rw;
        loadDetect_IFID  = i.ld;
        storeDetect_IFID = i.st;
        halt_IFID        = i.ht;
        ctrl_IFID        = i.ctrl;
    endtask

    // Drive one cycle, check the combinational stall, queue the expected image,
    // then compare it against the registered outputs after the edge.
    task automatic cycle(input instr_t i, input logic br, input logic sx,
                         input int mode, input logic exp_stall);
        exp_t e;
        exp_t got;
        apply(i);
        takeBranch_EXMEM = br;
        stall_EX         = sx;
        #1;
        chk("stall_IFID", 64'(stall_IFID), 64'(exp_stall));
        e = cur;
        case (mode)
            CAP: begin
                e.v = i.v;     e.a1 = i.a1;   e.a2 = i.a2;
                e.d1 = i.d1;   e.d2 = i.d2;   e.imm = i.imm;
                e.wr = i.wr;   e.ctrl = i.ctrl;
                e.rw = i.rw & i.v;  e.ld = i.ld & i.v;
                e.st = i.st & i.v;  e.ht = i.ht & i.v;
                e.halted = i.ht & i.v;
            end
            BUB: begin
                e.v = 1'b0; e.rw = 1'b0; e.ld = 1'b0; e.st = 1'b0; e.ht = 1'b0;
                e.bc = e.bc + 16'd1;
            end
            FLUSH: begin
                e.v = 1'b0; e.rw = 1'b0; e.ld = 1'b0; e.st = 1'b0; e.ht = 1'b0;
                e.halted = 1'b0;
            end
            default: ;
        endcase
        if (exp_stall) e.sc = e.sc + 16'd1;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        got = sb_q.pop_front();
        cmp_outs(got);
        cur = got;
    endtask

    initial begin
        instr_t i;
        rst_n = 1'b0;
        apply(instr_t'(0));
        takeBranch_EXMEM = 1'b0;
        stall_EX         = 1'b0;
        cur              = exp_t'(0);
        #2;
        cmp_outs(cur);
        @(negedge clk);
        rst_n = 1'b1;

        // Load-use: LD r3, then ADD reading r3 on source 2
        cycle(mk(1, 3'd1, 1, 3'd2, 1, 3'd3, 1, 1, 0, 0), 0, 0, CAP, 0);
        i = mk(1, 3'd5, 1, 3'd3, 1, 3'd4, 1, 0, 0, 0);
        cycle(i, 0, 0, BUB, 1);
        cycle(i, 0, 0, CAP, 0);

        // No false hazard: unused source, then non-load producer
        cycle(mk(1, 3'd1, 1, 3'd2, 1, 3'd3, 1, 1, 0, 0), 0, 0, CAP, 0);
        cycle(mk(1, 3'd3, 0, 3'd6, 1, 3'd3, 1, 0, 0, 0), 0, 0, CAP, 0);
        cycle(mk(1, 3'd3, 1, 3'd3, 1, 3'd5, 1, 0, 0, 0), 0, 0, CAP, 0);

        // Flush beats a simultaneous load-use hazard
        cycle(mk(1, 3'd0, 1, 3'd0, 1, 3'd2, 1, 1, 0, 0), 0, 0, CAP, 0);
        i = mk(1, 3'd2, 1, 3'd4, 1, 3'd6, 1, 0, 0, 0);
        cycle(i, 1, 0, FLUSH, 0);
        cycle(i, 0, 0, CAP, 0);

        // Downstream hold for three cycles with changing IF/ID contents
        for (int k = 0; k < 3; k++) cycle(rnd_instr(), 0, 1, HOLD, 1);

        // Downstream hold over a pending hazard, then the bubble on release
        cycle(mk(1, 3'd0, 1, 3'd1, 1, 3'd7, 1, 1, 0, 0), 0, 0, CAP, 0);
        i = mk(1, 3'd7, 1, 3'd2, 1, 3'd1, 0, 0, 1, 0);
        cycle(i, 0, 1, HOLD, 1);
        cycle(i, 0, 0, BUB, 1);
        cycle(i, 0, 0, CAP, 0);

        // Invalid slot: flags must not survive capture
        cycle(mk(0, 3'd4, 1, 3'd5, 1, 3'd6, 1, 1, 1, 1), 0, 0, CAP, 0);

        // Halt capture, sticky hold, cleared by a flush
        cycle(mk(1, 3'd0, 0, 3'd0, 0, 3'd0, 0, 0, 0, 1), 0, 0, CAP, 0);
        cycle(rnd_instr(), 0, 0, HOLD, 1);
        cycle(rnd_instr(), 0, 0, HOLD, 1);
        cycle(rnd_instr(), 1, 0, FLUSH, 0);
        cycle(mk(1, 3'd1, 1, 3'd2, 1, 3'd3, 1, 0, 0, 0), 0, 0, CAP, 0);

        // Long downstream hold drives stallCnt into saturation
        stall_EX = 1'b1;
        repeat (65540) @(posedge clk);
        #1;
        chk("stallCnt_sat",  64'(stallCnt),   64'(16'hFFFF));
        chk("bubbleCnt_sat", 64'(bubbleCnt),  64'(cur.bc));
        chk("valid_held",    64'(valid_IDEX), 64'(1'b1));

        // Asynchronous reset mid-cycle clears everything without a clock edge
        #2;
        rst_n = 1'b0;
        #1;
        cmp_outs(exp_t'(0));
        stall_EX = 1'b0;
        #10;
        rst_n = 1'b1;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
